// File: rtl/game_timer_if.sv
// Signal bundle between the game state machine / pickup / HUD side and game_timer.
// The timer itself connects through the slave modport.
interface game_timer_if;
  logic       game_on;
  logic [1:0] level_sel;
  logic       add_time;
  logic       one_sec_pulse;
  logic       timer_ended;
  logic       low_time;
  logic [3:0] min_digit;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;

  modport master (
    output game_on, level_sel, add_time,
    input  one_sec_pulse, timer_ended, low_time, min_digit, sec_tens, sec_ones
  );

  modport slave (
    input  game_on, level_sel, add_time,
    output one_sec_pulse, timer_ended, low_time, min_digit, sec_tens, sec_ones
  );
endinterface

// File: rtl/game_timer.sv
// Level countdown timer with a free-running one-second prescaler.
// Also produces the low-time warning and the M:SS digits for the HUD.
module game_timer #(
  parameter int unsigned CLK_FREQ_HZ   = 31_500_000,
  parameter int unsigned L1_SECONDS    = 120,
  parameter int unsigned L2_SECONDS    = 90,
  parameter int unsigned BONUS_SECONDS = 15,
  parameter int unsigned WARN_SECONDS  = 10
) (
  input logic         clk,
  input logic         reset,
  game_timer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRunning, StExpired} state_e;

  localparam int unsigned PreW    = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(CLK_FREQ_HZ - 1);
  localparam logic [9:0]  L1Count   = 10'(L1_SECONDS);
  localparam logic [9:0]  L2Count   = 10'(L2_SECONDS);
  localparam logic [9:0]  WarnCount = 10'(WARN_SECONDS);
  localparam logic [10:0] BonusAdd  = 11'(BONUS_SECONDS);
  localparam logic [10:0] MaxCount  = 11'd599;
  localparam logic [3:0]  RstMin    = 4'(L1_SECONDS / 60);
  localparam logic [3:0]  RstTens   = 4'((L1_SECONDS % 60) / 10);
  localparam logic [3:0]  RstOnes   = 4'(L1_SECONDS % 10);

  logic [PreW-1:0] pre_q;
  logic            game_on_q;
  state_e          state_q;
  logic [9:0]      count_q;
  logic            rise;
  logic            tick;
  logic [9:0]      load_val;
  logic [10:0]     bonus_sum;
  logic [9:0]      run_val;

  assign rise              = bus.game_on & ~game_on_q;
  assign tick              = (pre_q == PreLast);
  assign bus.one_sec_pulse = tick;

  // Bonus saturates before the tick is taken, so a tick at the ceiling yields 598.
  always_comb begin
    load_val  = (bus.level_sel == 2'd2) ? L2Count : L1Count;
    bonus_sum = {1'b0, count_q};
    if (bus.add_time) begin
      bonus_sum = bonus_sum + BonusAdd;
    end
    if (bonus_sum > MaxCount) begin
      bonus_sum = MaxCount;
    end
    run_val = bonus_sum[9:0];
    if (tick) begin
      run_val = run_val - 10'd1;
    end
  end

  // Prescaler never stops; the game state machine times its waits from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else if (rise || tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      count_q         <= L1Count;
      game_on_q       <= 1'b0;
      bus.timer_ended <= 1'b0;
      bus.low_time    <= 1'b0;
      bus.min_digit   <= RstMin;
      bus.sec_tens    <= RstTens;
      bus.sec_ones    <= RstOnes;
    end else begin
      game_on_q     <= bus.game_on;
      bus.low_time  <= (state_q == StRunning) && (count_q != '0) && (count_q <= WarnCount);
      bus.min_digit <= 4'(count_q / 10'd60);
      bus.sec_tens  <= 4'((count_q % 10'd60) / 10'd10);
      bus.sec_ones  <= 4'(count_q % 10'd10);
      if (rise) begin
        state_q         <= StRunning;
        count_q         <= load_val;
        bus.timer_ended <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            bus.timer_ended <= 1'b0;
          end
          StRunning: begin
            if (!bus.game_on) begin
              state_q <= StIdle;
            end else begin
              count_q <= run_val;
              if (run_val == '0) begin
                state_q         <= StExpired;
                bus.timer_ended <= 1'b1;
              end
            end
          end
          StExpired: begin
            count_q         <= '0;
            bus.timer_ended <= 1'b1;
          end
          default: begin
            state_q         <= StIdle;
            bus.timer_ended <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_timer.sv
// Randomized bench for game_timer: a seconds-level reference model checked every cycle,
// plus literal expectations at the scenario points.
module tb_game_timer;

  localparam int N  = 10;
  localparam int L1 = 120;
  localparam int L2 = 90;
  localparam int B  = 15;
  localparam int W  = 10;

  logic clk = 1'b0;
  logic reset;
  game_timer_if bus ();

  game_timer #(
    .CLK_FREQ_HZ  (N),
    .L1_SECONDS   (L1),
    .L2_SECONDS   (L2),
    .BONUS_SECONDS(B),
    .WARN_SECONDS (W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 expired; seconds kept as plain ints.
  int m_mode, m_count, m_phase, m_dig, m_te, m_low;
  logic m_prev;
  int nx_mode, nx_count, nx_phase;

  always_comb begin
    nx_mode  = m_mode;
    nx_count = m_count;
    nx_phase = (m_phase == N - 1) ? 0 : m_phase + 1;
    if (bus.game_on && !m_prev) begin
      nx_mode  = 1;
      nx_count = (bus.level_sel == 2'd2) ? L2 : L1;
      nx_phase = 0;
    end else if (m_mode == 1) begin
      if (!bus.game_on) begin
        nx_mode = 0;
      end else begin
        nx_count = m_count + (bus.add_time ? B : 0);
        if (nx_count > 599) nx_count = 599;
        if (m_phase == N - 1) nx_count = nx_count - 1;
        if (nx_count == 0) nx_mode = 2;
      end
    end else if (m_mode == 2) begin
      nx_count = 0;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode  <= 0;
      m_count <= L1;
      m_phase <= 0;
      m_prev  <= 1'b0;
      m_dig   <= L1;
      m_te    <= 0;
      m_low   <= 0;
    end else begin
      m_prev  <= bus.game_on;
      m_dig   <= m_count;
      m_low   <= int'(m_mode == 1 && m_count > 0 && m_count <= W);
      m_mode  <= nx_mode;
      m_count <= nx_count;
      m_phase <= nx_phase;
      m_te    <= int'(nx_mode == 2);
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    check("one_sec_pulse", int'(bus.one_sec_pulse), int'(m_phase == N - 1));
    check("timer_ended", int'(bus.timer_ended), m_te);
    check("low_time", int'(bus.low_time), m_low);
    check("min_digit", int'(bus.min_digit), m_dig / 60);
    check("sec_tens", int'(bus.sec_tens), (m_dig % 60) / 10);
    check("sec_ones", int'(bus.sec_ones), m_dig % 10);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_digits(input string name, input int mn, input int tn, input int on);
    check({name, "_min"}, int'(bus.min_digit), mn);
    check({name, "_tens"}, int'(bus.sec_tens), tn);
    check({name, "_ones"}, int'(bus.sec_ones), on);
  endtask

  initial begin
    int k;
    int pulses;
    reset         = 1'b1;
    bus.game_on   = 1'b0;
    bus.level_sel = 2'd1;
    bus.add_time  = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_digits("reset", 2, 0, 0);
    check("reset_timer_ended", int'(bus.timer_ended), 0);

    // Level-1 start: first tick 10 cycles after load, digits a cycle later.
    bus.game_on = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
    check_digits("l1_start", 1, 5, 9);

    // Sparse random bonuses while running.
    for (int i = 0; i < 300; i++) begin
      bus.add_time = ($urandom_range(0, 39) == 0);
      step();
    end
    bus.add_time = 1'b0;

    // Pause at 50: count frozen, no warning.
    k = 0;
    while (!(m_mode == 1 && m_count == 50) && k < 8000) begin step(); k++; end
    if (k >= 8000) check("wait_count_50", m_count, 50);
    bus.game_on = 1'b0;
    repeat (35) step();
    check_digits("pause", 0, 5, 0);
    check("pause_low_time", int'(bus.low_time), 0);
    bus.game_on = 1'b1;
    step();
    step();
    check_digits("reload", 2, 0, 0);

    // Bonus in the same cycle as the tick at count 1.
    k = 0;
    while (!(m_mode == 1 && m_count == 1 && m_phase == N - 1) && k < 1500) begin
      step();
      k++;
    end
    if (k >= 1500) check("wait_count_1", m_count, 1);
    bus.add_time = 1'b1;
    step();
    bus.add_time = 1'b0;
    step();
    check_digits("bonus_tick", 0, 1, 5);
    check("bonus_tick_ended", int'(bus.timer_ended), 0);

    // Run to expiry; bonus ignored; timer_ended survives game_on falling.
    k = 0;
    while (m_mode != 2 && k < 300) begin step(); k++; end
    if (k >= 300) check("wait_expired", m_mode, 2);
    check("expired_ended", int'(bus.timer_ended), 1);
    bus.add_time = 1'b1;
    step();
    bus.add_time = 1'b0;
    step();
    check_digits("expired_bonus", 0, 0, 0);
    bus.game_on = 1'b0;
    repeat (20) step();
    check("expired_hold", int'(bus.timer_ended), 1);
    bus.level_sel = 2'd2;
    bus.game_on   = 1'b1;
    step();
    check("l2_load_ended", int'(bus.timer_ended), 0);
    step();
    check_digits("l2_load", 1, 3, 0);

    // Saturation at 599.
    k = 0;
    while (m_count < 585 && k < 100) begin bus.add_time = 1'b1; step(); k++; end
    bus.add_time = 1'b0;
    while (m_phase > N - 4) step();
    bus.add_time = 1'b1;
    step();
    bus.add_time = 1'b0;
    step();
    check_digits("saturate", 9, 5, 9);

    // Free random traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) bus.game_on = ~bus.game_on;
      bus.add_time  = ($urandom_range(0, 7) == 0);
      bus.level_sel = 2'($urandom_range(0, 3));
      step();
    end
    bus.add_time = 1'b0;

    // Asynchronous reset mid-run.
    bus.game_on   = 1'b0;
    bus.level_sel = 2'd1;
    step();
    bus.game_on = 1'b1;
    repeat (15) step();
    reset = 1'b1;
    bus.game_on = 1'b0;
    #1;
    check_digits("async_reset", 2, 0, 0);
    check("async_reset_ended", int'(bus.timer_ended), 0);
    check("async_reset_low", int'(bus.low_time), 0);
    check("async_reset_pulse", int'(bus.one_sec_pulse), 0);
    repeat (3) step();
    reset = 1'b0;
    pulses = 0;
    repeat (30) begin
      step();
      pulses += int'(bus.one_sec_pulse);
    end
    check("pulses_after_reset", pulses, 3);
    check_digits("post_reset_idle", 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
